// File: rtl/murmur_4_bytes.sv
// murmur_4_bytes
//   Hashes one right-justified ASCII word (up to 32 characters) with
//   MurmurHash3 x86_32, one 4-byte block per clock. The finished hash is
//   then compared against a list of forbidden-word hashes.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   enable      in   request level, held high until ready is seen
//   ready       out  result valid, held until enable is sampled low
//   word        in   [256:1] ASCII word, last character in word[8:1],
//                    unused upper bytes are 8'h00
//   hash        out  [31:0] MurmurHash3 x86_32 of the word
//   is_present  out  1 when hash equals any DICT entry
//
// Handshake is 4-phase. A request is taken only in IDLE. After the result
// is posted, the FSM waits in DONE until enable is seen low.
module murmur_4_bytes #(
  parameter logic [31:0]               SEED        = 32'h0000_0000,
  parameter int                        NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*32-1:0] DICT        = {32'hBA6BD213, 32'h248BFA47,
                                                      32'hFFFFFFFF, 32'hFFFFFFFF}
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic         ready,
  input  logic [256:1] word,
  output logic [31:0]  hash,
  output logic         is_present
);

  localparam logic [31:0] C1 = 32'hcc9e2d51;
  localparam logic [31:0] C2 = 32'h1b873593;
  localparam logic [31:0] C3 = 32'h85ebca6b;
  localparam logic [31:0] C4 = 32'hc2b2ae35;

  typedef enum logic [2:0] {
    IDLE, LOAD, BLOCK, TAIL, FMIX1, FMIX2, DONE
  } state_t;

  state_t       state, state_nxt;
  logic [255:0] w;      // latched word; left-aligned in LOAD so b0 sits at [255:248]
  logic [31:0]  h;
  logic [5:0]   len;
  logic [3:0]   cnt;    // blocks still to be consumed

  logic [5:0]   len_c;
  logic [5:0]   pad;
  logic [8:0]   shamt;
  logic [31:0]  blk;
  logic [31:0]  k1;
  logic [31:0]  h_fin;

  function automatic logic [31:0] rotl15(input logic [31:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [31:0] rotl13(input logic [31:0] x);
    return {x[18:0], x[31:19]};
  endfunction

  function automatic logic [31:0] scramble_k(input logic [31:0] k);
    logic [31:0] t;
    t = k * C1;
    t = rotl15(t);
    t = t * C2;
    return t;
  endfunction

  function automatic logic [31:0] mix_h(input logic [31:0] hv, input logic [31:0] k);
    logic [31:0] t;
    t = hv ^ k;
    t = rotl13(t);
    t = t * 32'd5 + 32'he6546b64;
    return t;
  endfunction

  function automatic logic [31:0] fmix1(input logic [31:0] hv, input logic [5:0] n);
    logic [31:0] t;
    t = hv ^ {26'd0, n};
    t = t ^ (t >> 16);
    t = t * C3;
    return t;
  endfunction

  function automatic logic [31:0] fmix2(input logic [31:0] hv);
    logic [31:0] t;
    t = hv ^ (hv >> 13);
    t = t * C4;
    t = t ^ (t >> 16);
    return t;
  endfunction

  // Length runs from the most-significant non-zero byte down to byte 0, so
  // zero bytes embedded after the first character still count.
  function automatic logic [5:0] word_len(input logic [255:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[8*i +: 8] != 8'h00) n = 6'(i + 1);
    end
    return n;
  endfunction

  function automatic logic dict_hit(input logic [31:0] hv);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hv == DICT[32*i +: 32]) hit = 1'b1;
    end
    return hit;
  endfunction

  assign len_c = word_len(w);
  assign pad   = 6'd32 - len_c;
  assign shamt = {pad, 3'b000};

  // After left alignment the next block's bytes are the top four bytes of w,
  // read little-endian. Bytes past the end of the word are shifted-in zeros,
  // so the tail word needs no explicit masking.
  assign blk   = {w[231:224], w[239:232], w[247:240], w[255:248]};
  assign k1    = {8'h00, w[239:232], w[247:240], w[255:248]};
  assign h_fin = fmix2(h);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = LOAD;
      LOAD:    state_nxt = (len_c[5:2] != 4'd0) ? BLOCK : TAIL;
      BLOCK:   if (cnt == 4'd1) state_nxt = TAIL;
      TAIL:    state_nxt = FMIX1;
      FMIX1:   state_nxt = FMIX2;
      FMIX2:   state_nxt = DONE;
      DONE:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      hash       <= '0;
      is_present <= 1'b0;
      h          <= '0;
      w          <= '0;
      len        <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (enable) begin
            w <= word;
            h <= SEED;
          end
        end
        LOAD: begin
          len <= len_c;
          cnt <= len_c[5:2];
          w   <= w << shamt;
        end
        BLOCK: begin
          h   <= mix_h(h, scramble_k(blk));
          w   <= w << 32;
          cnt <= cnt - 4'd1;
        end
        TAIL: begin
          if (len[1:0] != 2'd0) h <= h ^ scramble_k(k1);
        end
        FMIX1: begin
          h <= fmix1(h, len);
        end
        FMIX2: begin
          h          <= h_fin;
          hash       <= h_fin;
          is_present <= dict_hit(h_fin);
          ready      <= 1'b1;
        end
        DONE: begin
          if (!enable) ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_murmur_4_bytes.sv
// Testbench for murmur_4_bytes. Two instances share all inputs: one with
// SEED=0 and one with SEED=1. Expected hashes come from a byte-level
// MurmurHash3 x86_32 reference model and from known constants.
module tb_murmur_4_bytes;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [256:1] word;
  logic         ready0, ready1;
  logic [31:0]  hash0, hash1;
  logic         present0, present1;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  murmur_4_bytes #(.SEED(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .ready(ready0),
    .word(word), .hash(hash0), .is_present(present0)
  );

  murmur_4_bytes #(.SEED(32'h0000_0001)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .ready(ready1),
    .word(word), .hash(hash1), .is_present(present1)
  );

  typedef struct {
    string        name;
    logic [255:0] w;
    int           edges;
    logic [31:0]  h;
    logic         p;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_len(input logic [255:0] w);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (n == 0 && w[8*i +: 8] != 8'h00) n = i + 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_hash(input logic [255:0] w, input logic [31:0] seed);
    logic [7:0]  b[$];
    int          n, tail, base;
    logic [31:0] h, k;
    n = ref_len(w);
    for (int i = n - 1; i >= 0; i--) b.push_back(w[8*i +: 8]);
    h = seed;
    for (int j = 0; j < n / 4; j++) begin
      k = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
      k = k * 32'hcc9e2d51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1b873593;
      h = h ^ k;
      h = (h << 13) | (h >> 19);
      h = h * 32'd5 + 32'he6546b64;
    end
    tail = n % 4;
    base = n - tail;
    k = 32'd0;
    if (tail >= 3) k = k ^ (32'(b[base+2]) << 16);
    if (tail >= 2) k = k ^ (32'(b[base+1]) << 8);
    if (tail >= 1) begin
      k = k ^ 32'(b[base]);
      k = k * 32'hcc9e2d51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1b873593;
      h = h ^ k;
    end
    h = h ^ 32'(n);
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  function automatic logic ref_present(input logic [31:0] h);
    return (h == 32'hBA6BD213) || (h == 32'h248BFA47) || (h == 32'hFFFFFFFF);
  endfunction

  // One full handshake: raise enable, wait for ready (bounded), check both
  // instances, drop enable and check that ready falls on the next edge.
  task automatic run_req(input string name, input logic [255:0] w, input int exp_edges,
                         input logic [31:0] exp_h, input logic exp_p);
    int          edges;
    bit          seen;
    logic [31:0] h1;
    @(negedge clock);
    word   = w;
    enable = 1'b1;
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clock);
      edges++;
      #1;
      if (ready0) seen = 1'b1;
    end
    chk({name, " latency"}, 32'(edges), 32'(exp_edges));
    chk({name, " hash"}, hash0, exp_h);
    chk({name, " is_present"}, {31'd0, present0}, {31'd0, exp_p});
    h1 = ref_hash(w, 32'h1);
    chk({name, " seed1 ready"}, {31'd0, ready1}, 32'd1);
    chk({name, " seed1 hash"}, hash1, h1);
    chk({name, " seed1 is_present"}, {31'd0, present1}, {31'd0, ref_present(h1)});
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    chk({name, " ready drop"}, {31'd0, ready0}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w;
    int           n, edges;
    bit           seen;

    vecs[0] = '{"hello", 256'("hello"), 6, 32'h248BFA47, 1'b1};
    vecs[1] = '{"test",  256'("test"),  6, 32'hBA6BD213, 1'b1};
    vecs[2] = '{"empty", 256'd0,        5, 32'h00000000, 1'b0};
    vecs[3] = '{"a32",   {32{8'h61}},  13, ref_hash({32{8'h61}}, 32'h0), 1'b0};

    reset  = 1'b1;
    enable = 1'b0;
    word   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset ready", {31'd0, ready0}, 32'd0);
    chk("reset hash", hash0, 32'd0);
    chk("reset is_present", {31'd0, present0}, 32'd0);
    chk("reset seed1 hash", hash1, 32'd0);

    // table vectors
    for (int i = 0; i < 4; i++) begin
      run_req(vecs[i].name, vecs[i].w, vecs[i].edges, vecs[i].h, vecs[i].p);
      if (i == 2) chk("empty seed1 const", hash1, 32'h514E28B7);
    end

    // enable dropped mid-computation and word changed after start
    @(negedge clock);
    word   = 256'("hello");
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    word   = 256'("test");
    edges  = 1;
    seen   = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clock);
      edges++;
      #1;
      if (ready0) seen = 1'b1;
    end
    chk("drop latency", 32'(edges), 32'd6);
    chk("drop hash", hash0, 32'h248BFA47);
    @(posedge clock);
    #1;
    chk("drop one-cycle ready", {31'd0, ready0}, 32'd0);
    @(posedge clock);
    #1;
    chk("drop hash held", hash0, 32'h248BFA47);

    // reset during BLOCK of a 32-character word
    @(negedge clock);
    word   = {32{8'h61}};
    enable = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    chk("abort ready", {31'd0, ready0}, 32'd0);
    chk("abort hash", hash0, 32'd0);
    chk("abort is_present", {31'd0, present0}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_req("post-abort hello", 256'("hello"), 6, 32'h248BFA47, 1'b1);

    // randomized words with embedded zero bytes
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(0, 32);
      w = '0;
      for (int k = 0; k < n; k++) begin
        logic [7:0] bv;
        bv = 8'($urandom);
        if ($urandom_range(0, 7) == 0) bv = 8'h00;
        if (k == 0 && bv == 8'h00) bv = 8'h41;
        w[8*(n-1-k) +: 8] = bv;
      end
      run_req($sformatf("rand%0d len%0d", t, n), w, ref_len(w) / 4 + 5,
              ref_hash(w, 32'h0), ref_present(ref_hash(w, 32'h0)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/murmur_4_bytes.md
Name: murmur_4_bytes

Overview:
- Hashes one right-justified ASCII word of up to 32 characters with MurmurHash3 x86_32, one 4-byte block per clock.
- Compares the 32-bit hash against a parameterised list of forbidden-word hashes and flags a match.
- Sits between the word tokenizer and the censoring logic.
- Uses a 4-phase enable/ready handshake.

Parameters:
- SEED, 32'h0000_0000, MurmurHash3 seed loaded into h at start.
- NUM_ENTRIES, 4, number of forbidden-hash entries.
- DICT, {32'hBA6BD213, 32'h248BFA47, 32'hFFFFFFFF, 32'hFFFFFFFF}, packed NUM_ENTRIES*32 list. Entry i is DICT[32*i+31:32*i]; the last-listed value is entry 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  request; level, held high until ready seen.
- ready  out  1  result valid; held until enable sampled low.
- word  in  [256:1]  ASCII word, right-justified. The last char is in word[8:1]; unused upper bytes are 8'h00.
- hash  out  32  MurmurHash3 x86_32 of the word.
- is_present  out  1  1 when hash equals any DICT entry.

Behaviour:
- Reset (sync, priority over all): state=IDLE; ready=0, hash=0, is_present=0; internal h, k and counters are cleared.
- Word parsing:
  - len = count of bytes from the most-significant non-zero byte down to word[8:1]. Range 0..32; embedded 00 bytes after the first non-zero byte are counted.
  - The first character b0 is the most-significant non-zero byte.
  - Block j = {b(4j+3), b(4j+2), b(4j+1), b(4j)}, i.e. little-endian byte order.
  - nb = len/4 (floor); tail = len%4.
- FSM:
  - IDLE: when enable=1, latch word, h<=SEED, go to LOAD. enable=0 stays IDLE.
  - LOAD: compute len/nb. Go to BLOCK if nb>0, else TAIL.
  - BLOCK (one block per cycle, nb cycles):
    - k=blk*32'hcc9e2d51; k=rotl(k,15); k*=32'h1b873593.
    - h^=k; h=rotl(h,13); h=h*5+32'he6546b64.
  - TAIL (always 1 cycle): if tail>0:
    - k1=b(4nb) | b(4nb+1)<<8 (if tail≥2) | b(4nb+2)<<16 (if tail=3).
    - k1*=c1; rotl15; *=c2; h^=k1.
  - FMIX1: h^=len; h^=h>>16; h*=32'h85ebca6b.
  - FMIX2: h^=h>>13; h*=32'hc2b2ae35; h^=h>>16. Register hash<=h and is_present<=OR of (h==DICT[i]). Set ready<=1 and go to DONE.
  - DONE: hold ready, hash and is_present. When enable is sampled 0: ready<=0, go to IDLE. hash and is_present keep their values until the next FMIX2.
- Arithmetic: all multiplies and adds are mod 2^32 (truncate to 32 bits); shifts are logical.
- Latency: counting the IDLE edge that samples enable=1 as edge 1, ready is high after edge nb+5. Examples: "hello" after 6 edges; empty word after 5 edges.
- enable dropping mid-computation is ignored: the computation completes, ready is high for exactly 1 cycle, then the FSM returns to IDLE.
- word changes after the IDLE start edge are ignored.
- A new request starts only from IDLE. It requires ready to have fallen, i.e. one cycle with enable=0 seen in DONE.
- reset mid-operation aborts immediately to the reset state.

Test Plan:
- Reset for 2 cycles, then release -> ready=0, hash=0, is_present=0, state IDLE.
- word="hello" (right-justified), enable=1, SEED=0 -> ready rises after 6 edges; hash=32'h248BFA47, is_present=1. Drop enable -> ready=0 next cycle.
- word="test", enable=1 -> ready after 6 edges; hash=32'hBA6BD213, is_present=1.
- word=all zeros (len 0), SEED=0 -> ready after 5 edges, hash=0, is_present=0. Repeat with SEED=1 -> hash=32'h514E28B7.
- 32-char word of 'a' -> ready after 13 edges. hash equals software MurmurHash3_x86_32 of "aaaa...a" (32 chars), checked by a reference model; is_present=0.
- Assert reset during BLOCK of a 32-char word -> outputs 0 the next cycle. Then a fresh "hello" request -> hash=32'h248BFA47.
